// File: rtl/activation_scheduler.sv
// Shares one fixed-latency activation unit among NUM_REQ requesters: tag pipeline plus credit-protected result FIFO.
// Define ACT_SCHED_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module activation_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int ACT_LATENCY = 9,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         act_input,
    input  logic [DATA_WIDTH-1:0]         act_output,
    output logic                          res_valid,
    output logic [DATA_WIDTH-1:0]         res_data,
    output logic [ID_WIDTH-1:0]           res_id,
    input  logic                          res_ready,
    output logic                          busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW   = PTR_W + 1;
    localparam int CNT_W = $clog2(ACT_LATENCY + FIFO_DEPTH + 1);

    logic [ACT_LATENCY-1:0] tag_v_q;
    logic [ID_WIDTH-1:0]    tag_id_q [ACT_LATENCY];
    logic [DATA_WIDTH-1:0]  act_input_q, act_input_d;
    logic [DATA_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]    fifo_id_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [FCW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]       inflight_cnt;
    logic                   credit_ok, grant_found, accept, push, pop;
    logic [ID_WIDTH-1:0]    grant_id;

`ifdef ACT_SCHED_RR_EN
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    int                  rr_idx;
`endif

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
`ifdef ACT_SCHED_RR_EN
        rr_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[rr_idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_WIDTH'(rr_idx);
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_found = 1'b1;
                grant_id    = ID_WIDTH'(k);
            end
        end
`endif
    end

    always_comb begin
        inflight_cnt = '0;
        for (int s = 0; s < ACT_LATENCY; s++) begin
            inflight_cnt = inflight_cnt + CNT_W'(tag_v_q[s]);
        end
    end

    // A pop in this cycle deliberately frees no credit, keeping ready off the res_ready path.
    assign credit_ok   = (inflight_cnt + CNT_W'(fifo_cnt_q)) < CNT_W'(FIFO_DEPTH);
    assign accept      = grant_found && credit_ok;
    assign req_ready   = accept ? (NUM_REQ'(1) << grant_id) : '0;
    assign act_input_d = accept ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign push       = tag_v_q[ACT_LATENCY-1];
    assign res_valid  = (fifo_cnt_q != '0);
    assign pop        = res_valid && res_ready;
    assign fifo_cnt_d = fifo_cnt_q + FCW'(push) - FCW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q     <= '0;
            for (int s = 0; s < ACT_LATENCY; s++) tag_id_q[s] <= '0;
            act_input_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            tag_v_q[0]  <= accept;
            tag_id_q[0] <= accept ? grant_id : '0;
            for (int s = 1; s < ACT_LATENCY; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
            act_input_q <= act_input_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= act_output;
            fifo_id_q[wr_ptr_q]   <= tag_id_q[ACT_LATENCY-1];
        end
        if (rst_n && push) begin
            assert (fifo_cnt_q != FCW'(FIFO_DEPTH))
            else $error("activation_scheduler: result written into a full FIFO");
        end
    end

`ifdef ACT_SCHED_RR_EN
    assign rr_ptr_d = !accept ? rr_ptr_q :
                      (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign act_input = act_input_q;
    assign res_data  = res_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign res_id    = res_valid ? fifo_id_q[rd_ptr_q] : '0;
    assign busy      = (inflight_cnt != '0) || res_valid;

endmodule
